// File: rtl/cross_bar_mux_arbiter_if.sv
// Bus bundle for the AXI-Stream packet merger: per-channel inputs plus the merged output.
// slave is the merger's view, master is the view of whatever drives the inputs and sinks the output.
interface cross_bar_mux_arbiter_if #(
   parameter int MSEL_WIDTH = 2,
   parameter int CHANNEL_NO = 2**MSEL_WIDTH,
   parameter int DATA_WIDTH = 32
);
   logic [CHANNEL_NO-1:0][DATA_WIDTH-1:0] s_axis_tdata;
   logic [CHANNEL_NO-1:0]                 s_axis_tvalid;
   logic [CHANNEL_NO-1:0]                 s_axis_tlast;
   logic [CHANNEL_NO-1:0]                 s_axis_tready;
   logic [DATA_WIDTH-1:0]                 m_axis_tdata;
   logic                                  m_axis_tvalid;
   logic                                  m_axis_tlast;
   logic [MSEL_WIDTH-1:0]                 m_axis_tid;
   logic                                  m_axis_tready;

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
   );
endinterface

// File: rtl/cross_bar_mux_arbiter.sv
// Merges CHANNEL_NO AXI-Stream inputs onto one output, arbitrating round-robin per packet
// so packets are never interleaved; the output beat sits in a single register stage.
module cross_bar_mux_arbiter #(
   parameter int MSEL_WIDTH = 2,
   parameter int CHANNEL_NO = 2**MSEL_WIDTH,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  aclk,
   input  logic                  areset,
   cross_bar_mux_arbiter_if.slave bus
);
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   localparam logic [MSEL_WIDTH-1:0] LAST_GRANT_RST = MSEL_WIDTH'(CHANNEL_NO - 1);

   state_e                 state_q, state_d;
   logic [MSEL_WIDTH-1:0]  grant_q, grant_d;
   logic [MSEL_WIDTH-1:0]  last_grant_q, last_grant_d;
   logic [DATA_WIDTH-1:0]  m_tdata_q, m_tdata_d;
   logic                   m_tvalid_q, m_tvalid_d;
   logic                   m_tlast_q, m_tlast_d;
   logic [MSEL_WIDTH-1:0]  m_tid_q, m_tid_d;

   logic [MSEL_WIDTH-1:0]  pick_s;
   logic                   any_req_s;
   logic                   out_free_s;
   logic                   accept_s;
   logic [CHANNEL_NO-1:0]  s_tready_s;

   function automatic logic [MSEL_WIDTH-1:0] rr_index(input logic [MSEL_WIDTH-1:0] base,
                                                      input int offs);
      int sum;
      sum = (int'(base) + offs) % CHANNEL_NO;
      return MSEL_WIDTH'(sum);
   endfunction

   // Round-robin search starting just after the previous winner
   always_comb begin
      pick_s    = grant_q;
      any_req_s = 1'b0;
      for (int i = 1; i <= CHANNEL_NO; i++) begin
         if (!any_req_s && bus.s_axis_tvalid[rr_index(last_grant_q, i)]) begin
            any_req_s = 1'b1;
            pick_s    = rr_index(last_grant_q, i);
         end else begin
            any_req_s = any_req_s;
         end
      end
   end

   // Input handshake: only the granted channel may see ready, and only while the output can take a beat
   always_comb begin
      out_free_s = !m_tvalid_q || bus.m_axis_tready;
      s_tready_s = {CHANNEL_NO{1'b0}};
      if ((state_q == ACTIVE) && !areset) begin
         s_tready_s[grant_q] = out_free_s;
      end else begin
         s_tready_s = {CHANNEL_NO{1'b0}};
      end
      accept_s = s_tready_s[grant_q] && bus.s_axis_tvalid[grant_q];
   end

   // Packet-level state: hold the grant until the tlast beat is taken
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (any_req_s) begin
               state_d = ACTIVE;
               grant_d = pick_s;
            end else begin
               state_d = IDLE;
            end
         end
         ACTIVE: begin
            if (accept_s && bus.s_axis_tlast[grant_q]) begin
               state_d      = IDLE;
               last_grant_d = grant_q;
            end else begin
               state_d = ACTIVE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output register drains on its own, regardless of the arbitration state
   always_comb begin
      m_tdata_d  = m_tdata_q;
      m_tlast_d  = m_tlast_q;
      m_tid_d    = m_tid_q;
      m_tvalid_d = m_tvalid_q;
      if (accept_s) begin
         m_tdata_d  = bus.s_axis_tdata[grant_q];
         m_tlast_d  = bus.s_axis_tlast[grant_q];
         m_tid_d    = grant_q;
         m_tvalid_d = 1'b1;
      end else if (bus.m_axis_tready) begin
         m_tvalid_d = 1'b0;
      end else begin
         m_tvalid_d = m_tvalid_q;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q      <= IDLE;
         grant_q      <= {MSEL_WIDTH{1'b0}};
         last_grant_q <= LAST_GRANT_RST;
         m_tdata_q    <= {DATA_WIDTH{1'b0}};
         m_tvalid_q   <= 1'b0;
         m_tlast_q    <= 1'b0;
         m_tid_q      <= {MSEL_WIDTH{1'b0}};
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         m_tdata_q    <= m_tdata_d;
         m_tvalid_q   <= m_tvalid_d;
         m_tlast_q    <= m_tlast_d;
         m_tid_q      <= m_tid_d;
      end
   end

   assign bus.s_axis_tready = s_tready_s;
   assign bus.m_axis_tdata  = m_tdata_q;
   assign bus.m_axis_tvalid = m_tvalid_q;
   assign bus.m_axis_tlast  = m_tlast_q;
   assign bus.m_axis_tid    = m_tid_q;
endmodule

// File: tb/tb_cross_bar_mux_arbiter.sv
// Directed bench for cross_bar_mux_arbiter: per-channel packet sources, an output beat
// recorder, and one task per scenario with hand-computed expectations.
module tb_cross_bar_mux_arbiter;
   logic aclk;
   logic areset;

   cross_bar_mux_arbiter_if #(.MSEL_WIDTH(2), .CHANNEL_NO(4), .DATA_WIDTH(32)) bus ();

   cross_bar_mux_arbiter #(.MSEL_WIDTH(2), .CHANNEL_NO(4), .DATA_WIDTH(32)) dut (
      .aclk   (aclk),
      .areset (areset),
      .bus    (bus)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int n_cmp;
   int n_err;

   logic [31:0] src_data [4][8];
   logic        src_last [4][8];
   int          src_len  [4];
   int          src_idx  [4];
   bit          src_en   [4];
   bit          acc      [4];

   logic [31:0] out_data [$];
   logic        out_last [$];
   logic [1:0]  out_tid  [$];
   logic        vtrace   [$];

   task automatic clear_sources();
      for (int c = 0; c < 4; c++) begin
         src_len[c] = 0;
         src_idx[c] = 0;
         src_en[c]  = 1'b1;
         for (int b = 0; b < 8; b++) begin
            src_data[c][b] = 32'h0;
            src_last[c][b] = 1'b0;
         end
      end
   endtask

   task automatic drive_sources();
      for (int c = 0; c < 4; c++) begin
         if (src_en[c] && (src_idx[c] < src_len[c])) begin
            bus.s_axis_tvalid[c] = 1'b1;
            bus.s_axis_tdata[c]  = src_data[c][src_idx[c]];
            bus.s_axis_tlast[c]  = src_last[c][src_idx[c]];
         end else begin
            bus.s_axis_tvalid[c] = 1'b0;
            bus.s_axis_tdata[c]  = 32'h0;
            bus.s_axis_tlast[c]  = 1'b0;
         end
      end
   endtask

   // Sample handshakes 3 time units after the edge (inputs were driven at +2)
   task automatic sample();
      #1;
      for (int c = 0; c < 4; c++) acc[c] = bus.s_axis_tvalid[c] && bus.s_axis_tready[c];
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
         out_data.push_back(bus.m_axis_tdata);
         out_last.push_back(bus.m_axis_tlast);
         out_tid.push_back(bus.m_axis_tid);
      end
      vtrace.push_back(bus.m_axis_tvalid);
   endtask

   task automatic advance();
      @(posedge aclk);
      #2;
      for (int c = 0; c < 4; c++) if (acc[c]) src_idx[c]++;
      drive_sources();
   endtask

   task automatic step();
      sample();
      advance();
   endtask

   task automatic clear_capture();
      out_data.delete();
      out_last.delete();
      out_tid.delete();
      vtrace.delete();
   endtask

   task automatic do_reset();
      areset = 1'b1;
      bus.m_axis_tready = 1'b1;
      clear_sources();
      drive_sources();
      step();
      step();
      areset = 1'b0;
      clear_capture();
   endtask

   task automatic test_reset();
      areset = 1'b1;
      bus.m_axis_tready = 1'b1;
      clear_sources();
      drive_sources();
      step();
      sample();
      n_cmp++;
      if (bus.s_axis_tready !== 4'b0000) begin
         n_err++; $display("FAIL reset_s_tready got=%b exp=0000", bus.s_axis_tready);
      end
      advance();
      areset = 1'b0;
      n_cmp++;
      if (bus.m_axis_tvalid !== 1'b0) begin
         n_err++; $display("FAIL reset_m_tvalid got=%b exp=0", bus.m_axis_tvalid);
      end
      n_cmp++;
      if (bus.m_axis_tlast !== 1'b0) begin
         n_err++; $display("FAIL reset_m_tlast got=%b exp=0", bus.m_axis_tlast);
      end
      n_cmp++;
      if (bus.m_axis_tdata !== 32'h0) begin
         n_err++; $display("FAIL reset_m_tdata got=%h exp=0", bus.m_axis_tdata);
      end
      n_cmp++;
      if (bus.m_axis_tid !== 2'd0) begin
         n_err++; $display("FAIL reset_m_tid got=%0d exp=0", bus.m_axis_tid);
      end
      clear_capture();
   endtask

   // ch1 and ch3 request together; ch1 wins first after reset
   task automatic test_two_channels();
      logic [31:0] exp_d [4];
      logic        exp_l [4];
      logic [1:0]  exp_t [4];
      exp_d = '{32'hA1, 32'hA2, 32'hC1, 32'hC2};
      exp_l = '{1'b0, 1'b1, 1'b0, 1'b1};
      exp_t = '{2'd1, 2'd1, 2'd3, 2'd3};
      do_reset();
      src_len[1] = 2; src_data[1][0] = 32'hA1; src_data[1][1] = 32'hA2; src_last[1][1] = 1'b1;
      src_len[3] = 2; src_data[3][0] = 32'hC1; src_data[3][1] = 32'hC2; src_last[3][1] = 1'b1;
      drive_sources();
      for (int k = 0; k < 12; k++) step();
      n_cmp++;
      if (out_data.size() !== 4) begin
         n_err++; $display("FAIL two_ch_count got=%0d exp=4", out_data.size());
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (i >= out_data.size()) begin
            n_err++; $display("FAIL two_ch_beat%0d missing exp=%h", i, exp_d[i]);
         end else if (out_data[i] !== exp_d[i] || out_last[i] !== exp_l[i] || out_tid[i] !== exp_t[i]) begin
            n_err++;
            $display("FAIL two_ch_beat%0d got=%h/%b/%0d exp=%h/%b/%0d", i, out_data[i], out_last[i],
                     out_tid[i], exp_d[i], exp_l[i], exp_t[i]);
         end
      end
      n_cmp++;
      if (bus.m_axis_tvalid !== 1'b0) begin
         n_err++; $display("FAIL two_ch_idle_tvalid got=%b exp=0", bus.m_axis_tvalid);
      end
   endtask

   // Every channel always has a one-beat packet: strict rotation, one beat per two cycles
   task automatic test_round_robin();
      logic exp_v;
      do_reset();
      for (int c = 0; c < 4; c++) begin
         src_len[c] = 2;
         for (int b = 0; b < 2; b++) begin
            src_data[c][b] = 32'((c << 4) | b);
            src_last[c][b] = 1'b1;
         end
      end
      drive_sources();
      for (int k = 0; k < 18; k++) step();
      for (int k = 0; k < 18; k++) begin
         exp_v = (k >= 2) && (k <= 16) && ((k % 2) == 0);
         n_cmp++;
         if (vtrace[k] !== exp_v) begin
            n_err++; $display("FAIL rr_tvalid_cycle%0d got=%b exp=%b", k, vtrace[k], exp_v);
         end
      end
      n_cmp++;
      if (out_tid.size() !== 8) begin
         n_err++; $display("FAIL rr_count got=%0d exp=8", out_tid.size());
      end
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (i >= out_tid.size()) begin
            n_err++; $display("FAIL rr_beat%0d missing", i);
         end else if (out_tid[i] !== 2'(i % 4) || out_data[i] !== 32'(((i % 4) << 4) | (i / 4))) begin
            n_err++;
            $display("FAIL rr_beat%0d got tid=%0d data=%h exp tid=%0d data=%h", i, out_tid[i],
                     out_data[i], i % 4, ((i % 4) << 4) | (i / 4));
         end
      end
   endtask

   // Downstream stalls three cycles right after the first beat of a 4-beat packet
   task automatic test_stall();
      do_reset();
      src_len[0] = 4;
      for (int b = 0; b < 4; b++) src_data[0][b] = 32'hD0 + 32'(b);
      src_last[0][3] = 1'b1;
      drive_sources();
      step();
      step();
      for (int k = 0; k < 3; k++) begin
         bus.m_axis_tready = 1'b0;
         sample();
         n_cmp++;
         if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 32'hD0 || bus.m_axis_tid !== 2'd0) begin
            n_err++;
            $display("FAIL stall_hold%0d got v=%b d=%h tid=%0d exp v=1 d=d0 tid=0", k,
                     bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tid);
         end
         n_cmp++;
         if (bus.s_axis_tready[0] !== 1'b0) begin
            n_err++; $display("FAIL stall_s_tready%0d got=%b exp=0", k, bus.s_axis_tready[0]);
         end
         advance();
      end
      bus.m_axis_tready = 1'b1;
      for (int k = 0; k < 10; k++) step();
      n_cmp++;
      if (out_data.size() !== 4) begin
         n_err++; $display("FAIL stall_count got=%0d exp=4", out_data.size());
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (i >= out_data.size()) begin
            n_err++; $display("FAIL stall_beat%0d missing", i);
         end else if (out_data[i] !== 32'hD0 + 32'(i) || out_last[i] !== (i == 3) || out_tid[i] !== 2'd0) begin
            n_err++;
            $display("FAIL stall_beat%0d got=%h/%b/%0d exp=%h/%b/0", i, out_data[i], out_last[i],
                     out_tid[i], 32'hD0 + 32'(i), (i == 3));
         end
      end
   endtask

   // ch2 source pauses mid-packet while ch0 waits; ch0 must not cut in
   task automatic test_gap_no_interleave();
      do_reset();
      src_len[2] = 4;
      for (int b = 0; b < 4; b++) src_data[2][b] = 32'hE0 + 32'(b);
      src_last[2][3] = 1'b1;
      src_len[0] = 1; src_data[0][0] = 32'hF0; src_last[0][0] = 1'b1; src_en[0] = 1'b0;
      drive_sources();
      for (int k = 0; k < 3; k++) step();
      src_en[2] = 1'b0;
      src_en[0] = 1'b1;
      drive_sources();
      for (int k = 0; k < 5; k++) begin
         sample();
         n_cmp++;
         if (bus.s_axis_tready[0] !== 1'b0) begin
            n_err++; $display("FAIL gap_ch0_ready%0d got=%b exp=0", k, bus.s_axis_tready[0]);
         end
         n_cmp++;
         if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tid !== 2'd2) begin
            n_err++; $display("FAIL gap_tid%0d got=%0d exp=2", k, bus.m_axis_tid);
         end
         advance();
      end
      src_en[2] = 1'b1;
      drive_sources();
      for (int k = 0; k < 15; k++) step();
      n_cmp++;
      if (out_data.size() !== 5) begin
         n_err++; $display("FAIL gap_count got=%0d exp=5", out_data.size());
      end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (i >= out_data.size()) begin
            n_err++; $display("FAIL gap_beat%0d missing", i);
         end else if (i < 4 && (out_data[i] !== 32'hE0 + 32'(i) || out_tid[i] !== 2'd2)) begin
            n_err++;
            $display("FAIL gap_beat%0d got=%h/%0d exp=%h/2", i, out_data[i], out_tid[i], 32'hE0 + 32'(i));
         end else if (i == 4 && (out_data[i] !== 32'hF0 || out_tid[i] !== 2'd0 || out_last[i] !== 1'b1)) begin
            n_err++;
            $display("FAIL gap_beat4 got=%h/%0d/%b exp=f0/0/1", out_data[i], out_tid[i], out_last[i]);
         end
      end
   endtask

   // Reset lands after two beats of a 4-beat ch1 packet with one beat held at the output
   task automatic test_reset_mid_packet();
      logic [31:0] exp_d [3];
      logic [1:0]  exp_t [3];
      exp_d = '{32'hB0, 32'h50, 32'h51};
      exp_t = '{2'd1, 2'd0, 2'd1};
      do_reset();
      src_len[1] = 4;
      for (int b = 0; b < 4; b++) src_data[1][b] = 32'hB0 + 32'(b);
      src_last[1][3] = 1'b1;
      drive_sources();
      for (int k = 0; k < 3; k++) step();
      areset = 1'b1;
      bus.m_axis_tready = 1'b0;
      sample();
      n_cmp++;
      if (bus.s_axis_tready !== 4'b0000) begin
         n_err++; $display("FAIL rstmid_ready_in_reset got=%b exp=0000", bus.s_axis_tready);
      end
      advance();
      n_cmp++;
      if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tdata !== 32'h0 || bus.m_axis_tid !== 2'd0) begin
         n_err++;
         $display("FAIL rstmid_out_cleared got v=%b d=%h tid=%0d exp 0/0/0", bus.m_axis_tvalid,
                  bus.m_axis_tdata, bus.m_axis_tid);
      end
      sample();
      n_cmp++;
      if (bus.s_axis_tready !== 4'b0000) begin
         n_err++; $display("FAIL rstmid_ready_after got=%b exp=0000", bus.s_axis_tready);
      end
      advance();
      areset = 1'b0;
      clear_sources();
      src_len[0] = 1; src_data[0][0] = 32'h50; src_last[0][0] = 1'b1;
      src_len[1] = 1; src_data[1][0] = 32'h51; src_last[1][0] = 1'b1;
      bus.m_axis_tready = 1'b1;
      drive_sources();
      for (int k = 0; k < 10; k++) step();
      n_cmp++;
      if (out_data.size() !== 3) begin
         n_err++; $display("FAIL rstmid_count got=%0d exp=3", out_data.size());
      end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (i >= out_data.size()) begin
            n_err++; $display("FAIL rstmid_beat%0d missing", i);
         end else if (out_data[i] !== exp_d[i] || out_tid[i] !== exp_t[i]) begin
            n_err++;
            $display("FAIL rstmid_beat%0d got=%h/%0d exp=%h/%0d", i, out_data[i], out_tid[i],
                     exp_d[i], exp_t[i]);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      areset = 1'b1;
      bus.m_axis_tready = 1'b1;
      bus.s_axis_tvalid = 4'b0000;
      bus.s_axis_tlast  = 4'b0000;
      bus.s_axis_tdata  = '0;
      @(posedge aclk);
      #2;
      test_reset();
      test_two_channels();
      test_round_robin();
      test_stall();
      test_gap_no_interleave();
      test_reset_mid_packet();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/cross_bar_mux_arbiter.md
CROSS_BAR_MUX_ARBITER -- requirements
Module: cross_bar_mux_arbiter

Interface
REQ-001 SHALL have parameter MSEL_WIDTH, default 2, meaning channel index width.
REQ-002 SHALL have parameter CHANNEL_NO, default 2**MSEL_WIDTH, meaning number of input channels.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning tdata width.
REQ-004 SHALL have port aclk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port areset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port s_axis_tdata  input  DATA_WIDTH x [CHANNEL_NO]  per-channel input data.
REQ-007 SHALL have port s_axis_tvalid  input  1 x [CHANNEL_NO]  per-channel input valid.
REQ-008 SHALL have port s_axis_tlast  input  1 x [CHANNEL_NO]  per-channel end-of-packet.
REQ-009 SHALL have port s_axis_tready  output  1 x [CHANNEL_NO]  per-channel input ready.
REQ-010 SHALL have port m_axis_tdata  output  DATA_WIDTH  merged output data.
REQ-011 SHALL have port m_axis_tvalid  output  1  merged output valid.
REQ-012 SHALL have port m_axis_tlast  output  1  merged end-of-packet.
REQ-013 SHALL have port m_axis_tid  output  MSEL_WIDTH  index of the source channel of the current beat.
REQ-014 SHALL have port m_axis_tready  input  1  downstream ready.

Function
REQ-015 SHALL merge CHANNEL_NO AXI-Stream inputs onto one output with packet-granular arbitration; no packet is ever interleaved with another.
REQ-016 SHALL implement states IDLE and ACTIVE, plus registers grant[MSEL_WIDTH-1:0] and last_grant[MSEL_WIDTH-1:0].
REQ-017 In IDLE, when any s_axis_tvalid is 1, SHALL select the first requesting channel searching round-robin from last_grant+1 (mod CHANNEL_NO), load it into grant, and enter ACTIVE next cycle.
REQ-018 In IDLE, all s_axis_tready SHALL be 0 (one-cycle arbitration bubble per packet).
REQ-019 In ACTIVE, s_axis_tready[grant] SHALL equal (!m_axis_tvalid || m_axis_tready); s_axis_tready of every other channel SHALL be 0.
REQ-020 A beat is accepted when s_axis_tvalid[grant] && s_axis_tready[grant]; its tdata, tlast and grant SHALL load into the output register (m_axis_tdata/tlast/tid) with m_axis_tvalid=1 on the next cycle (latency 1).
REQ-021 When m_axis_tvalid && m_axis_tready and no new beat is accepted in the same cycle, m_axis_tvalid SHALL go 0; simultaneous drain and accept SHALL sustain 1 beat/cycle.
REQ-022 While m_axis_tvalid && !m_axis_tready, m_axis_tdata, m_axis_tlast and m_axis_tid SHALL hold stable.
REQ-023 On acceptance of a beat with tlast=1, SHALL return to IDLE next cycle and set last_grant<=grant.
REQ-024 Single-beat packets (tlast on first beat) SHALL be handled identically to REQ-023.
REQ-025 If s_axis_tvalid[grant] drops mid-packet, SHALL remain ACTIVE on the same grant indefinitely; no timeout.
REQ-026 Requests on non-granted channels SHALL be ignored until the current packet's tlast is accepted.
REQ-027 The output register SHALL drain independently of state; returning to IDLE SHALL NOT clear a pending m_axis_tvalid.

Reset
REQ-028 When areset=1 at a clock edge, state SHALL become IDLE, grant 0, last_grant CHANNEL_NO-1 (channel 0 has first priority).
REQ-029 When areset=1, m_axis_tvalid, m_axis_tlast, m_axis_tdata and m_axis_tid SHALL become 0; s_axis_tready SHALL be 0 for all channels while in reset and IDLE.
REQ-030 Reset mid-packet SHALL discard the partial packet and any held output beat with no further output activity.

Verification
REQ-031 After reset, ch1 and ch3 valid together, 2-beat packets 0xA1,0xA2 / 0xC1,0xC2, m_tready=1 -> ch1 granted first: output 0xA1,0xA2(tlast) tid=1, then 0xC1,0xC2(tlast) tid=3.
REQ-032 All 4 channels continuously valid with 1-beat packets -> tid sequence 0,1,2,3,0,... and m_tvalid pattern one beat every 2 cycles.
REQ-033 Ch0 4-beat packet with m_tready low 3 cycles after first beat -> m_tdata/tid held stable, s_tready[0]=0 while stalled, no beat lost or duplicated.
REQ-034 Ch2 granted, s_tvalid[2] drops 5 cycles mid-packet while ch0 valid -> no ch0 beat appears until ch2 tlast accepted.
REQ-035 areset asserted after 2 of 4 beats of ch1 packet -> next cycle m_tvalid=0, all s_tready=0; after release ch0 valid -> ch0 granted first.
